// File: rtl/multibyte_add_ctrl.sv
// multibyte_add_ctrl
//   Arbitrates two requesters onto one shared 8-bit carry-select adder and
//   performs each NBYTES-wide add as NBYTES byte-serial passes, LSB first.
//   The inter-byte carry is held in a register between passes.
//
// CarrySelect8bit (helper, same file)
//   a, b    in  8  operand bytes
//   cin     in  1  carry-in
//   sum     out 8  sum byte
//   cout    out 1  carry-out
//
// multibyte_add_ctrl ports (W = 8*NBYTES)
//   clk, rst_n                 clock, async active-low reset
//   reqX_valid/ready           requester X handshake (ready is combinational)
//   reqX_a, reqX_b, reqX_cin   requester X operands, sampled at handshake only
//   res_valid/ready            result handshake
//   res_sum, res_cout, res_ovf sum, unsigned carry-out, signed overflow
//   res_id                     requester that owns the result

module CarrySelect8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi_c0;
  logic [4:0] hi_c1;

  // Upper nibble is precomputed for both possible carries and picked by the
  // lower nibble's carry-out.
  always_comb begin
    lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi_c0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi_c1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum[3:0] = lo[3:0];
    if (lo[4]) begin
      sum[7:4] = hi_c1[3:0];
      cout     = hi_c1[4];
    end else begin
      sum[7:4] = hi_c0[3:0];
      cout     = hi_c0[4];
    end
  end

endmodule

module multibyte_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_cin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout,
  output logic                res_ovf,
  output logic                res_id
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          last_grant_q, last_grant_d;
  logic          id_q, id_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_sum_q, res_sum_d;
  logic          res_cout_q, res_cout_d;
  logic          res_ovf_q, res_ovf_d;
  logic          res_id_q, res_id_d;

  logic          grant;
  logic          hs0, hs1;
  logic [7:0]    add_a, add_b, add_sum;
  logic          add_cout;

  CarrySelect8bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    add_a = a_q[8*cnt_q +: 8];
    add_b = b_q[8*cnt_q +: 8];
  end

  // Round-robin only matters when both are valid; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // rst_n gates ready so no handshake can be seen while reset is asserted.
  always_comb begin
    req0_ready = rst_n && (state_q == S_IDLE) && !grant && req0_valid;
    req1_ready = rst_n && (state_q == S_IDLE) &&  grant && req1_valid;
    hs0        = req0_ready;
    hs1        = req1_ready;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_ovf_d    = res_ovf_q;
    res_id_d     = res_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (hs0) begin
          a_d          = req0_a;
          b_d          = req0_b;
          carry_d      = req0_cin;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_RUN;
        end else if (hs1) begin
          a_d          = req1_a;
          b_d          = req1_b;
          carry_d      = req1_cin;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        res_sum_d[8*cnt_q +: 8] = add_sum;
        carry_d                 = add_cout;
        if (cnt_q == CNT_LAST) begin
          // Counter parks at zero so it never exceeds NBYTES-1.
          cnt_d      = '0;
          res_cout_d = add_cout;
          res_ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
          res_id_d   = id_q;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_ovf_q    <= res_ovf_d;
      res_id_q     <= res_id_d;
    end
  end

  always_comb begin
    res_valid = (state_q == S_DONE);
    res_sum   = res_sum_q;
    res_cout  = res_cout_q;
    res_ovf   = res_ovf_q;
    res_id    = res_id_q;
  end

endmodule
